// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: round-robin, burst-granular sharing of the VGA pixel-write port among NREQ draw engines.
// Define VGA_PLOT_WATCHDOG_EN to build the stuck-owner watchdog that drives timeout_err.
module vga_plot_arbiter #(
    parameter int NREQ    = 4,
    parameter int XW      = 8,
    parameter int YW      = 7,
    parameter int CW      = 3,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      pix_valid,
    input  logic [NREQ-1:0]      pix_last,
    input  logic [NREQ*XW-1:0]   pix_x,
    input  logic [NREQ*YW-1:0]   pix_y,
    input  logic [NREQ*CW-1:0]   pix_colour,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      pix_ready,
    output logic [XW-1:0]        vga_x,
    output logic [YW-1:0]        vga_y,
    output logic [CW-1:0]        vga_colour,
    output logic                 vga_plot,
    output logic                 busy,
    output logic [IDW-1:0]       owner,
    output logic                 timeout_err
);
    typedef enum logic {IDLE, BURST} state_t;
    state_t          state_q;
    logic [NREQ-1:0] gnt_q;
    logic [IDW-1:0]  owner_q, rr_ptr_q, sel, idx, next_ptr;
    logic [XW-1:0]   x_q;
    logic [YW-1:0]   y_q;
    logic [CW-1:0]   c_q;
    logic            plot_q, acc, rel, wd_hit;

    assign acc      = (state_q == BURST) && pix_valid[owner_q];
    assign rel      = (acc && pix_last[owner_q]) || !req[owner_q] || wd_hit;
    assign next_ptr = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

    // First requester at or after the round-robin pointer; lowest rotation distance wins.
    always_comb begin
        sel = '0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IDW'((int'(rr_ptr_q) + k) % NREQ);
            if (req[idx]) sel = idx;
        end
    end

    // Grant FSM plus registered pixel pass-through to the VGA adapter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            c_q      <= '0;
            plot_q   <= 1'b0;
        end else begin
            plot_q <= acc;
            if (acc) begin
                x_q <= pix_x[owner_q*XW +: XW];
                y_q <= pix_y[owner_q*YW +: YW];
                c_q <= pix_colour[owner_q*CW +: CW];
            end
            if (state_q == IDLE) begin
                if (|req) begin
                    state_q <= BURST;
                    gnt_q   <= NREQ'(1) << sel;
                    owner_q <= sel;
                end
            end else if (rel) begin
                state_q  <= IDLE;
                gnt_q    <= '0;
                rr_ptr_q <= next_ptr;
            end
        end
    end

`ifdef VGA_PLOT_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wd_q;
    logic           err_q;

    assign wd_hit      = !acc && (wd_q == WDW'(TIMEOUT - 1));
    assign timeout_err = err_q;

    // Counts stalled burst cycles; expiry forces release and latches the sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else if (state_q != BURST || acc) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + 1'b1;
            if (wd_hit) err_q <= 1'b1;
        end
    end
`else
    assign wd_hit      = 1'b0;
    assign timeout_err = (TIMEOUT < 0);
`endif

    assign gnt        = gnt_q;
    assign pix_ready  = gnt_q;
    assign vga_x      = x_q;
    assign vga_y      = y_q;
    assign vga_colour = c_q;
    assign vga_plot   = plot_q;
    assign busy       = (state_q == BURST);
    assign owner      = owner_q;
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb_vga_plot_arbiter: scoreboard bench; stimulus queues expected grants and plots, negedge monitor compares.
module tb_vga_plot_arbiter;
    localparam int NREQ = 4, XW = 8, YW = 7, CW = 3, IDW = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req, pix_valid, pix_last, gnt, pix_ready;
    logic [NREQ*XW-1:0]  pix_x;
    logic [NREQ*YW-1:0]  pix_y;
    logic [NREQ*CW-1:0]  pix_colour;
    logic [XW-1:0]       vga_x;
    logic [YW-1:0]       vga_y;
    logic [CW-1:0]       vga_colour;
    logic                vga_plot, busy, timeout_err;
    logic [IDW-1:0]      owner;

    logic                req_e [NREQ];
    logic                vld_e [NREQ];
    logic                last_e [NREQ];
    logic [XW-1:0]       x_e [NREQ];
    logic [YW-1:0]       y_e [NREQ];
    logic [CW-1:0]       c_e [NREQ];

    int n_vec = 0;
    int n_err = 0;
    logic [XW+YW+CW-1:0] exp_px [$];
    logic [NREQ-1:0]     exp_gnt [$];
    logic [NREQ-1:0]     prev_gnt = '0;

    always #5 clk = ~clk;

    vga_plot_arbiter #(.NREQ(NREQ), .XW(XW), .YW(YW), .CW(CW), .IDW(IDW), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .req(req), .pix_valid(pix_valid), .pix_last(pix_last),
        .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour), .gnt(gnt), .pix_ready(pix_ready),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .busy(busy), .owner(owner), .timeout_err(timeout_err)
    );

    always_comb begin
        req = '0;
        pix_valid = '0;
        pix_last = '0;
        pix_x = '0;
        pix_y = '0;
        pix_colour = '0;
        for (int i = 0; i < NREQ; i++) begin
            req[i] = req_e[i];
            pix_valid[i] = vld_e[i];
            pix_last[i] = last_e[i];
            pix_x[i*XW +: XW] = x_e[i];
            pix_y[i*YW +: YW] = y_e[i];
            pix_colour[i*CW +: CW] = c_e[i];
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic void px(input int x, input int y, input int c);
        exp_px.push_back({XW'(x), YW'(y), CW'(c)});
    endfunction

    task automatic set_px(input int e, input bit r, input bit v, input int x, input int y, input int c, input bit l);
        req_e[e] = r;
        vld_e[e] = v;
        x_e[e] = XW'(x);
        y_e[e] = YW'(y);
        c_e[e] = CW'(c);
        last_e[e] = l;
    endtask

    task automatic wait_gnt(input int e);
        int w;
        w = 0;
        do begin
            @(posedge clk); #1;
            w++;
        end while (!gnt[e] && w < 200);
        check("grant wait", 64'(gnt[e]), 64'd1);
    endtask

    // Engine model: presents pixel 0 eagerly, streams n pixels once granted, then drops valid (and req unless keep).
    task automatic engine(input int e, input int n, input int x0, input int y, input int c, input bit last_on, input bit keep);
        set_px(e, 1, 1, x0, y, c, last_on && n == 1);
        wait_gnt(e);
        for (int k = 0; k < n; k++) begin
            set_px(e, 1, 1, x0 + k, y, c, last_on && k == n - 1);
            @(posedge clk); #1;
        end
        set_px(e, keep, 0, x0, y, c, 0);
    endtask

    // Monitor: every plot must match the next expected pixel; every new grant must follow an idle gap.
    always @(negedge clk) begin
        if (vga_plot) begin
            if (exp_px.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected plot: got x=%0d y=%0d c=%0d, expected none", vga_x, vga_y, vga_colour);
            end else begin
                check("plot", {vga_x, vga_y, vga_colour}, exp_px.pop_front());
            end
        end
        if (gnt != prev_gnt && gnt != '0) begin
            if (exp_gnt.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected grant: got %b, expected none", gnt);
            end else begin
                check("grant after gap", {prev_gnt, gnt}, {NREQ'(0), exp_gnt.pop_front()});
            end
        end
        prev_gnt = gnt;
    end

    initial begin
        #100000;
        $display("FAIL global timeout: got no finish, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b1;
        for (int i = 0; i < NREQ; i++) set_px(i, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset state", {gnt, pix_ready, vga_x, vga_y, vga_colour, vga_plot, busy, owner, timeout_err}, '0);
        reset = 1'b0;

        // Single requester, three-pixel burst
        exp_gnt.push_back(4'b0010);
        px(10, 5, 3); px(11, 5, 3); px(12, 5, 3);
        set_px(1, 1, 1, 10, 5, 3, 0);
        @(posedge clk); #1;
        check("single gnt latency", {gnt, pix_ready}, {4'b0010, 4'b0010});
        check("single busy owner", {busy, owner}, {1'b1, 2'd1});
        for (int k = 0; k < 3; k++) begin
            set_px(1, 1, 1, 10 + k, 5, 3, k == 2);
            @(posedge clk); #1;
        end
        check("single release", {gnt, busy, vga_plot, vga_x}, {4'b0000, 1'b0, 1'b1, 8'd12});
        set_px(1, 0, 0, 0, 0, 0, 0);

        // Abort by owner 2 after one pixel; pointer moves to 3, so 3 beats pending 0
        exp_gnt.push_back(4'b0100); exp_gnt.push_back(4'b1000); exp_gnt.push_back(4'b0001);
        px(20, 2, 2); px(30, 3, 3); px(31, 3, 3); px(40, 0, 1);
        fork
            engine(2, 1, 20, 2, 2, 0, 0);
            engine(3, 2, 30, 3, 3, 1, 0);
            engine(0, 1, 40, 0, 1, 1, 0);
        join

        // Full contention from pointer 0: strict rotation, engine 0 wraps around
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_gnt.push_back(4'b0001); exp_gnt.push_back(4'b0010); exp_gnt.push_back(4'b0100);
        exp_gnt.push_back(4'b1000); exp_gnt.push_back(4'b0001);
        px(50, 0, 1); px(51, 0, 1); px(60, 1, 2); px(61, 1, 2); px(70, 2, 3);
        px(71, 2, 3); px(80, 3, 4); px(81, 3, 4); px(90, 0, 5); px(91, 0, 5);
        fork
            begin
                engine(0, 2, 50, 0, 1, 1, 1);
                engine(0, 2, 90, 0, 5, 1, 0);
            end
            engine(1, 2, 60, 1, 2, 1, 0);
            engine(2, 2, 70, 2, 3, 1, 0);
            engine(3, 2, 80, 3, 4, 1, 0);
            begin
                int w;
                w = 0;
                @(posedge clk); #1;
                while (gnt != 4'b0001 && w < 50) begin
                    @(posedge clk); #1;
                    w++;
                end
                check("non-owner ready", {gnt, pix_ready[2], vld_e[2]}, {4'b0001, 1'b0, 1'b1});
            end
        join

        // Single persistent requester is re-granted after each gap
        exp_gnt.push_back(4'b0010); exp_gnt.push_back(4'b0010);
        px(110, 9, 6); px(111, 9, 6); px(112, 9, 6); px(113, 9, 6);
        begin
            engine(1, 2, 110, 9, 6, 1, 1);
            engine(1, 2, 112, 9, 6, 1, 0);
        end

        // Reset during pixel 2 of a five-pixel burst
        exp_gnt.push_back(4'b1000);
        px(100, 4, 7); px(101, 4, 7);
        set_px(3, 1, 1, 100, 4, 7, 0);
        wait_gnt(3);
        @(posedge clk); #1;
        set_px(3, 1, 1, 101, 4, 7, 0);
        @(posedge clk); #1;
        set_px(3, 1, 1, 102, 4, 7, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("reset mid-burst", {gnt, pix_ready, vga_x, vga_y, vga_colour, vga_plot, busy, owner, timeout_err}, '0);
        reset = 1'b0;
        set_px(3, 0, 0, 0, 0, 0, 0);
        exp_gnt.push_back(4'b0010); exp_gnt.push_back(4'b0100);
        px(120, 1, 1); px(125, 2, 2);
        fork
            engine(1, 1, 120, 1, 1, 1, 0);
            engine(2, 1, 125, 2, 2, 1, 0);
        join

`ifdef VGA_PLOT_WATCHDOG_EN
        begin
            int n;
            exp_gnt.push_back(4'b0001);
            set_px(0, 1, 0, 0, 0, 0, 0);
            wait_gnt(0);
            n = 0;
            while (gnt[0] && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            check("watchdog release cycles", n, 8);
            check("timeout_err set", timeout_err, 1);
            set_px(0, 0, 0, 0, 0, 0, 0);
            repeat (3) @(posedge clk);
            #1;
            check("timeout_err sticky", {timeout_err, gnt}, {1'b1, 4'b0000});
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            check("timeout_err cleared", timeout_err, 0);
        end
`else
        check("timeout_err tied low", timeout_err, 0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("plots outstanding", exp_px.size(), 0);
        check("grants outstanding", exp_gnt.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/vga_plot_arbiter.md
Name: vga_plot_arbiter

Overview:
- Shares the single pixel-write port of the VGA adapter (x, y, colour, plot) among NREQ drawing engines, e.g. erase, player, enemy and screen sprite drawers.
- Each engine requests the port and, once granted, streams a burst of pixels ending with a last flag.
- Arbitration is round-robin at burst granularity, so one sprite's pixels are never interleaved with another's.
- Sits between the sprite draw engines and the VGA adapter. The draw-sequencing FSM stays the source of which engines are enabled.

Parameters:
- NREQ, 4, number of requesting draw engines (2..8).
- XW, 8, pixel x width (160-column screen).
- YW, 7, pixel y width (120-row screen).
- CW, 3, colour width.
- IDW, 2, owner index width; must equal clog2(NREQ).
- TIMEOUT, 255, idle-cycle limit for the watchdog (feature only).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  NREQ  per-engine request, held high for the whole burst
- pix_valid  in  NREQ  per-engine pixel-valid
- pix_last  in  NREQ  per-engine final pixel of burst, qualified by pix_valid
- pix_x  in  NREQ*XW  packed x, engine i at [i*XW +: XW]
- pix_y  in  NREQ*YW  packed y
- pix_colour  in  NREQ*CW  packed colour
- gnt  out  NREQ  one-hot grant, registered
- pix_ready  out  NREQ  equals gnt (combinational copy); pixel accepted when pix_valid[i] && pix_ready[i]
- vga_x  out  XW  to VGA adapter, registered
- vga_y  out  YW  registered
- vga_colour  out  CW  registered
- vga_plot  out  1  write strobe, registered
- busy  out  1  high while in state BURST
- owner  out  IDW  index of current or last grantee
- timeout_err  out  1  sticky watchdog flag (feature only; tied 0 otherwise)

Behaviour:
- Reset: gnt=0, vga_x/y/colour=0, vga_plot=0, busy=0, owner=0, rr_ptr=0, timeout_err=0, state=IDLE. Reset mid-burst aborts immediately; no further plot is issued.
- State IDLE:
  - If any req bit is high, select the first requester at or after rr_ptr (wrapping modulo NREQ).
  - Next cycle: gnt[sel]=1, owner=sel, state=BURST.
  - If no req is high, stay in IDLE.
  - Grant latency from req is exactly 1 cycle.
- State BURST:
  - Accepted pixel (pix_valid[owner] high) produces vga_x/y/colour equal to that pixel and vga_plot=1 on the next cycle. Latency is 1 cycle; throughput is 1 pixel per cycle.
  - vga_plot=0 in any cycle without an accepted pixel; vga_x/y/colour hold their last values.
  - Accepted pixel with pix_last[owner]: gnt clears next cycle, rr_ptr=(owner+1) mod NREQ, state=IDLE.
  - req[owner] low with no pixel accepted (abort): same release as last, no plot.
  - req[owner] low in the same cycle as an accepted pixel: the pixel is plotted, then release.
- Boundary conditions:
  - IDLE holds for one cycle between bursts, so back-to-back bursts have a 1-cycle gap.
  - Valid or last from non-owners is ignored. Their pix_ready is 0 and they must hold the pixel.
  - With a single persistent requester, it is re-granted after each 1-cycle IDLE gap.
  - rr_ptr wraps from NREQ-1 to 0.
  - Simultaneous requests from all engines are served in strict rotation; no engine is starved beyond NREQ-1 bursts.
- No coordinate clipping or range checks: values are passed through unchanged.

Optional Feature:
- Macro: VGA_PLOT_WATCHDOG_EN.
- Defined:
  - A counter clears on grant and on every accepted pixel, and increments each BURST cycle with no accepted pixel.
  - On reaching TIMEOUT: force release (as for abort), set timeout_err=1, advance rr_ptr.
  - timeout_err is cleared only by reset.
- Undefined: no counter is built, timeout_err is constant 0, and an owner may hold the port indefinitely.

Test Plan:
- Single requester: req[1]=1 with a 3-pixel burst (10,5,c=3),(11,5,3),(12,5,3 last) -> gnt=0010 one cycle after req. Three consecutive vga_plot pulses carry exactly those values, each 1 cycle after acceptance. gnt=0 the cycle after the last pixel.
- Contention: req=1111 held, each engine bursts 2 pixels -> grant order 0,1,2,3,0. One IDLE cycle between bursts. No plot carries a non-owner's coordinates.
- Non-owner isolation: engine 2 drives pix_valid=1 while engine 0 owns the port -> pix_ready[2]=0 and no vga_plot carries engine 2's data until it is granted.
- Abort: owner 2 drops req after 1 pixel without last -> exactly 1 plot, release next cycle, rr_ptr=3, next grant goes to req[3] if pending.
- Reset mid-burst: assert reset during pixel 2 of a 5-pixel burst -> next cycle all outputs 0, state IDLE. After reset deasserts, req=0110 is granted to engine 1.
- Watchdog (VGA_PLOT_WATCHDOG_EN, TIMEOUT=8): owner holds req with pix_valid=0 -> release after 8 idle cycles, timeout_err=1 and stays 1 until reset.
